// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder: FSM encoding, width bound,
// and the debug view exported by the top.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   carry_msb;
    } dbg_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bus of the serial adder. Both directions use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] augend;
    logic [WIDTH-1:0] addend;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, augend, addend, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, augend, addend, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic augend,
    input  logic addend,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = augend ^ addend ^ carry_in;
    assign carry_out = (augend & addend) | (carry_in & (augend ^ addend));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full adder
// cell, the sum fills in from the MSB side, result is held until taken.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_if.slave       bus,
    output dbg_t                dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range 1..64");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             carry_msb_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             out_valid_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             accept;

    full_adder u_cell (
        .augend    (a_q[0]),
        .addend    (b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = bus.in_ready && bus.in_valid;

    always_comb begin
        sum_shift            = sum_q >> 1;
        sum_shift[WIDTH-1]   = fa_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last_bit)     state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers carry no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_next == HOLD);
            if (state == IDLE && accept) begin
                a_q     <= bus.augend;
                b_q     <= bus.addend;
                carry_q <= bus.carry_in;
                cnt     <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                sum_q   <= sum_shift;
                carry_q <= fa_cout;
                cnt     <= cnt + CW'(1);
                if (last_bit) begin
                    carry_msb_q <= carry_q;
                    carry_out_q <= fa_cout;
                    overflow_q  <= carry_q ^ fa_cout;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

    assign dbg.state     = state;
    assign dbg.carry_msb = carry_msb_q;
endmodule
